// File: rtl/serial_rx_fifo_pkg.sv
// Shared project constants: serial link timing and the receive FIFO geometry.
// The FIFO depth is always derived from its address width so the two cannot drift apart.
package serial_rx_fifo_pkg;

  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int BAUD_RATE   = 115_200;
  localparam int BAUD_DIV    = CLK_FREQ_HZ / BAUD_RATE;

  localparam int FIFO_ADDR_BITS = 3;

  function automatic int depth_of(input int addr_bits);
    return 1 << addr_bits;
  endfunction

  localparam int FIFO_DEPTH = depth_of(FIFO_ADDR_BITS);

endpackage

// File: rtl/serial_rx_fifo_sync_fifo.sv
// Generic first-word-fall-through FIFO: storage, pointers, occupancy count and full/empty.
// Full/empty come from the count, so the pointers may wrap freely.
module sync_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter int ADDR_BITS = FIFO_ADDR_BITS,
  parameter int WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rd_data,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 wr_accept
);

  localparam logic [ADDR_BITS:0]   FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0]   COUNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
  localparam logic [ADDR_BITS-1:0] PTR_ONE    = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] rd_ptr_reg;
  logic [ADDR_BITS-1:0] wr_ptr_reg;
  logic [ADDR_BITS:0]   count_reg;
  logic                 do_pop;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign rd_data = mem[rd_ptr_reg];

  // A pop frees the slot the push needs, so a full FIFO still takes a push alongside a pop.
  assign do_pop    = rd_en & ~empty;
  assign wr_accept = wr_en & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      case ({wr_accept, do_pop})
        2'b10:   count_reg <= count_reg + COUNT_ONE;
        2'b01:   count_reg <= count_reg - COUNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// Receive-side byte buffer for a serial receiver: turns the level-held byte-valid into one push
// per byte, tracks dropped bytes in a sticky overflow flag and pulses irq per accepted byte.
module serial_rx_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter int ADDR_BITS = FIFO_ADDR_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rxData,
  input  logic               rxDataReady,
  input  logic               readStrobe,
  input  logic               clearOverflow,
  output logic [7:0]         dataOut,
  output logic               dataAvailable,
  output logic [ADDR_BITS:0] count,
  output logic               overflow,
  output logic               irq
);

  logic ready_prev_reg;
  logic overflow_reg;
  logic irq_reg;
  logic push_req;
  logic push_accept;
  logic fifo_full;
  logic fifo_empty;

  // readyPrev resets high so a byte-valid already asserted at reset release is not re-pushed.
  assign push_req = rxDataReady & ~ready_prev_reg;

  sync_fifo #(
    .ADDR_BITS (ADDR_BITS),
    .WIDTH     (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (push_req),
    .wr_data   (rxData),
    .rd_en     (readStrobe),
    .rd_data   (dataOut),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .wr_accept (push_accept)
  );

  assign dataAvailable = ~fifo_empty;
  assign overflow      = overflow_reg;
  assign irq           = irq_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_prev_reg <= 1'b1;
      overflow_reg   <= 1'b0;
      irq_reg        <= 1'b0;
    end else begin
      ready_prev_reg <= rxDataReady;
      irq_reg        <= push_accept;
      // A drop in the same cycle as a clear keeps the flag set.
      if (push_req & ~push_accept) begin
        overflow_reg <= 1'b1;
      end else if (clearOverflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

endmodule
